// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store initiator between execute and data memory.
//                Accepts one operation per transaction, drives a req/ack
//                memory port, returns a one-cycle writeback pulse and keeps
//                a sticky error flag for rejected or timed-out operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        ex_ready,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_is_load,
    output logic        wb_err,
    output logic [31:0] wb_data,
    output logic        err,
    output logic [1:0]  err_cause,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_RW_BOTH = 2'b10;
    localparam logic [1:0] CAUSE_RANGE   = 2'b11;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [7:0]  wait_cnt;

    logic        is_idle;
    logic        one_op;
    logic        addr_ok;
    logic        accept;
    logic        rej_both;
    logic        rej_range;
    logic        timeout_hit;
    logic        new_err;
    logic [1:0]  new_cause;

    assign is_idle   = (state == IDLE);
    assign one_op    = ex_read ^ ex_write;
    assign addr_ok   = (ex_addr < 32'(DEPTH));
    assign accept    = is_idle & ex_valid & one_op & addr_ok;
    assign rej_both  = is_idle & ex_valid & ex_read & ex_write;
    assign rej_range = is_idle & ex_valid & one_op & ~addr_ok;

    // wait_cnt counts the REQ cycles already spent without ack, so the
    // TIMEOUT-th unacknowledged cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (state == REQ) & ~mem_ack & (wait_cnt == 8'(TIMEOUT - 1));

    assign new_err   = rej_both | rej_range | timeout_hit;
    assign new_cause = rej_both  ? CAUSE_RW_BOTH :
                       rej_range ? CAUSE_RANGE   : CAUSE_TIMEOUT;

    assign ex_ready   = is_idle;
    assign stall      = ~is_idle;
    assign mem_req    = (state == REQ);
    assign mem_we     = mem_req & we_q;
    assign wb_valid   = (state == RESP);
    assign wb_is_load = wb_valid & ~we_q;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (mem_ack || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter and writeback capture.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            we_q      <= 1'b0;
            wait_cnt  <= 8'd0;
            wb_data   <= 32'd0;
            wb_err    <= 1'b0;
        end else if (accept) begin
            mem_addr  <= ex_addr;
            mem_wdata <= ex_wdata;
            we_q      <= ex_write;
            wait_cnt  <= 8'd0;
        end else if (state == REQ) begin
            if (mem_ack) begin
                wb_data <= we_q ? 32'd0 : mem_rdata;
                wb_err  <= 1'b0;
            end else if (timeout_hit) begin
                wb_data <= 32'd0;
                wb_err  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Sticky error: first cause is kept; a clear coinciding with a new
    // error yields the new error as the first cause.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err       <= 1'b0;
            err_cause <= 2'b00;
        end else if (new_err) begin
            err <= 1'b1;
            if (!err || err_clr) begin
                err_cause <= new_cause;
            end
        end else if (err_clr) begin
            err       <= 1'b0;
            err_cause <= 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: directed table,
//                corner-case sequences and randomized operations checked
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid = 1'b0, ex_read = 1'b0, ex_write = 1'b0;
    logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
    logic        ex_ready, stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic        wb_valid, wb_is_load, wb_err, err;
    logic [1:0]  err_cause;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn),
        .ex_valid(ex_valid), .ex_read(ex_read), .ex_write(ex_write),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_ready(ex_ready), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_err(wb_err),
        .wb_data(wb_data), .err(err), .err_cause(err_cause), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    // ---------------- memory device: ack after ack_delay extra cycles ----------
    logic [31:0] dev_mem [0:255];
    bit          loaded    = 1'b0;
    int          ack_delay = 0;
    bit          ack_en    = 1'b1;
    int          req_cyc   = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'd19;
        if (i == 4) return 32'd6;
        return 32'(i * 7) ^ 32'hA5A5_0000;
    endfunction

    assign mem_ack   = mem_req && ack_en && (req_cyc == ack_delay);
    assign mem_rdata = dev_mem[mem_addr[7:0]];

    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (mem_req && mem_ack && mem_we) begin
            dev_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(posedge clock) begin
        if (mem_req && !mem_ack) req_cyc <= req_cyc + 1;
        else                     req_cyc <= 0;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    bit          m_err   = 1'b0;
    logic [1:0]  m_cause = 2'b00;

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic model_error(input logic [1:0] c);
        if (!m_err) m_cause = c;
        m_err = 1'b1;
    endtask

    // Predicts the outcome of one operation from the rules of the unit.
    task automatic model_op(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input bit ackok,
                            input bit clr, output int e_req, output logic [31:0] e_data,
                            output bit e_load, output bit e_wberr);
        e_req = 0; e_data = 32'd0; e_load = 1'b0; e_wberr = 1'b0;
        if (clr) begin m_err = 1'b0; m_cause = 2'b00; end
        if (!rd && !wr) return;
        if (rd && wr)            begin model_error(2'b10); return; end
        if (addr >= 32'(DEPTH))  begin model_error(2'b11); return; end
        e_load = rd;
        if (!ackok || lat + 1 > TIMEOUT) begin
            e_req = TIMEOUT; e_wberr = 1'b1;
            model_error(2'b01);
        end else begin
            e_req = lat + 1;
            if (rd) e_data = ref_mem[addr[7:0]];
            else    ref_mem[addr[7:0]] = wdata;
        end
    endtask

    // Drives one operation and checks the full transaction against expectations.
    task automatic apply(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input bit ackok, input bit clr,
                         input int e_req, input logic [31:0] e_data, input bit e_load,
                         input bit e_wberr, input bit e_err, input logic [1:0] e_cause);
        int n = 0, guard = 0;
        bit seen = 0, gap = 0, unstable = 0;
        if (clr) begin
            @(negedge clock); err_clr = 1'b1;
            @(negedge clock); err_clr = 1'b0;
            check(tag, "clr_err", 32'(err), 32'd0);
            check(tag, "clr_cause", 32'(err_cause), 32'd0);
        end
        ack_delay = lat; ack_en = ackok;
        @(negedge clock);
        check(tag, "ready_idle", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_read = rd; ex_write = wr; ex_addr = addr; ex_wdata = wdata;
        @(negedge clock);
        ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
        if (e_req == 0) begin
            check(tag, "rej_req", 32'(mem_req), 32'd0);
            check(tag, "rej_wb", 32'(wb_valid), 32'd0);
            check(tag, "rej_ready", 32'(ex_ready), 32'd1);
            check(tag, "rej_err", 32'(err), 32'(e_err));
            check(tag, "rej_cause", 32'(err_cause), 32'(e_cause));
        end else begin
            while (!seen && !gap && guard < 300) begin
                if (wb_valid) begin
                    seen = 1'b1;
                    check(tag, "wb_is_load", 32'(wb_is_load), 32'(e_load));
                    check(tag, "wb_err", 32'(wb_err), 32'(e_wberr));
                    check(tag, "wb_data", wb_data, e_data);
                    check(tag, "err", 32'(err), 32'(e_err));
                    check(tag, "err_cause", 32'(err_cause), 32'(e_cause));
                    check(tag, "stall_wb", 32'(stall), 32'd1);
                end else if (mem_req) begin
                    n++;
                    if (mem_addr !== addr || mem_we !== wr || (wr && mem_wdata !== wdata))
                        unstable = 1'b1;
                    @(negedge clock);
                end else begin
                    gap = 1'b1;
                end
                guard++;
            end
            check(tag, "wb_seen", 32'(seen), 32'd1);
            check(tag, "req_cycles", 32'(n), 32'(e_req));
            check(tag, "req_stable", 32'(unstable), 32'd0);
            if (seen) begin
                @(negedge clock);
                check(tag, "ready_back", 32'(ex_ready), 32'd1);
                check(tag, "wb_pulse", 32'(wb_valid), 32'd0);
            end
        end
    endtask

    typedef struct {
        bit          rd, wr;
        logic [31:0] addr, wdata;
        int          lat;
        bit          ackok, clr;
        int          e_req;
        logic [31:0] e_data;
        bit          e_load, e_wberr, e_err;
        logic [1:0]  e_cause;
    } vec_t;

    initial begin
        vec_t        tbl [12];
        int          r; logic [31:0] d; bit l, w;
        int          wb_count;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        //            rd wr addr  wdata         lat ack clr req data          ld we er cause
        tbl[0]  = '{1, 0, 3,    0,            0,  1,  0,  1,  32'd19,       1, 0, 0, 2'b00};
        tbl[1]  = '{0, 1, 5,    32'hDEAD,     3,  1,  0,  4,  0,            0, 0, 0, 2'b00};
        tbl[2]  = '{1, 0, 5,    0,            1,  1,  0,  2,  32'hDEAD,     1, 0, 0, 2'b00};
        tbl[3]  = '{1, 0, 7,    0,            0,  0,  0,  15, 0,            1, 1, 1, 2'b01};
        tbl[4]  = '{1, 1, 2,    0,            0,  1,  1,  0,  0,            0, 0, 1, 2'b10};
        tbl[5]  = '{1, 0, 256,  0,            0,  1,  0,  0,  0,            0, 0, 1, 2'b10};
        tbl[6]  = '{0, 0, 9,    0,            0,  1,  0,  0,  0,            0, 0, 1, 2'b10};
        tbl[7]  = '{0, 1, 300,  32'h55,       0,  1,  1,  0,  0,            0, 0, 1, 2'b11};
        tbl[8]  = '{1, 0, 4,    0,            0,  1,  1,  1,  32'd6,        1, 0, 0, 2'b00};
        tbl[9]  = '{0, 1, 255,  32'h12345678, 0,  1,  0,  1,  0,            0, 0, 0, 2'b00};
        tbl[10] = '{1, 0, 255,  0,            2,  1,  0,  3,  32'h12345678, 1, 0, 0, 2'b00};
        tbl[11] = '{1, 0, 3,    0,            14, 1,  0,  15, 32'd19,       1, 0, 0, 2'b00};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset", "ex_ready", 32'(ex_ready), 32'd1);
        check("reset", "stall", 32'(stall), 32'd0);
        check("reset", "mem_req", 32'(mem_req), 32'd0);
        check("reset", "wb_valid", 32'(wb_valid), 32'd0);
        check("reset", "err", 32'(err), 32'd0);
        check("reset", "mem_addr", mem_addr, 32'd0);
        check("reset", "wb_data", wb_data, 32'd0);
        resetn = 1'b1;

        // Directed table
        foreach (tbl[i]) begin
            model_op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
                     tbl[i].ackok, tbl[i].clr, r, d, l, w);
            apply($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                  tbl[i].lat, tbl[i].ackok, tbl[i].clr, tbl[i].e_req, tbl[i].e_data,
                  tbl[i].e_load, tbl[i].e_wberr, tbl[i].e_err, tbl[i].e_cause);
        end

        // Clear coinciding with a new error: the new cause wins
        @(negedge clock);
        err_clr = 1'b1; ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b1; ex_addr = 32'd1;
        @(negedge clock);
        err_clr = 1'b0; ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
        check("clr_vs_new", "err", 32'(err), 32'd1);
        check("clr_vs_new", "cause", 32'(err_cause), 32'b10);

        // Asynchronous reset during the 2nd REQ cycle
        ack_delay = 10; ack_en = 1'b1;
        @(negedge clock);
        ex_valid = 1'b1; ex_read = 1'b1; ex_addr = 32'd8;
        @(negedge clock);
        ex_valid = 1'b0; ex_read = 1'b0;
        check("rst_mid", "req_1st", 32'(mem_req), 32'd1);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid", "req_drop", 32'(mem_req), 32'd0);
        check("rst_mid", "ready", 32'(ex_ready), 32'd1);
        check("rst_mid", "stall", 32'(stall), 32'd0);
        check("rst_mid", "err", 32'(err), 32'd0);
        check("rst_mid", "cause", 32'(err_cause), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        m_err = 1'b0; m_cause = 2'b00;
        wb_count = 0;
        repeat (12) begin
            @(negedge clock);
            if (wb_valid || mem_req) wb_count++;
        end
        check("rst_mid", "no_activity", 32'(wb_count), 32'd0);
        model_op(1, 0, 32'd4, 0, 0, 1, 0, r, d, l, w);
        apply("rst_next", 1, 0, 32'd4, 0, 0, 1, 0, r, d, l, w, m_err, m_cause);

        // Randomized operations against the reference model
        for (int k = 0; k < 60; k++) begin
            bit rd, wr, ackok, clr;
            logic [31:0] addr, wdata;
            int lat, sel;
            sel   = $urandom_range(0, 19);
            rd    = (sel < 9) || (sel == 18);
            wr    = (sel >= 9 && sel < 17) || (sel == 18);
            addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 400))
                                                : 32'($urandom_range(0, 15));
            wdata = $urandom;
            lat   = $urandom_range(0, 4);
            ackok = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            model_op(rd, wr, addr, wdata, lat, ackok, clr, r, d, l, w);
            apply($sformatf("rnd%0d", k), rd, wr, addr, wdata, lat, ackok, clr,
                  r, d, l, w, m_err, m_cause);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the execute stage and the data memory. It accepts one memory operation per transaction from execute and drives a req/ack memory port, which tolerates multi-cycle memory latency. Completion goes back to writeback as a single-cycle result pulse. It holds `stall` while a transaction is in flight and reports rejected or timed-out operations through a sticky error.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words in data memory; legal word addresses are 0..DEPTH-1.
- `TIMEOUT`, 15: maximum cycles spent in REQ without `mem_ack` before abort (1..255).

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents an operation this cycle.
- `ex_read`  in  1  operation is a load.
- `ex_write`  in  1  operation is a store.
- `ex_addr`  in  32  word address.
- `ex_wdata`  in  32  store data.
- `ex_ready`  out  1  unit idle and able to accept an operation.
- `stall`  out  1  pipeline stall; equals NOT `ex_ready`.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  32  request word address.
- `mem_wdata`  out  32  request write data.
- `mem_ack`  in  1  memory completes the request; may be combinational in the same cycle as `mem_req`.
- `mem_rdata`  in  32  read data; valid in the cycle `mem_ack` is high.
- `wb_valid`  out  1  single-cycle completion pulse.
- `wb_is_load`  out  1  completed operation was a load.
- `wb_err`  out  1  completed operation was aborted.
- `wb_data`  out  32  load data; 0 for stores and aborts.
- `err`  out  1  sticky error flag.
- `err_cause`  out  2  cause of the first error: 01 timeout, 10 read and write both set, 11 address out of range.
- `err_clr`  in  1  synchronous clear of `err` and `err_cause`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `ex_ready`=1. An operation is accepted when `ex_valid` & `ex_ready` & (`ex_read` ^ `ex_write`) & (`ex_addr` < DEPTH).
  - On accept: latch address, write data and direction, then go to REQ.
- Rejection, while in IDLE with `ex_valid` high:
  - `ex_read` & `ex_write` both set: reject with cause 10.
  - `ex_addr` >= DEPTH with exactly one of `ex_read`/`ex_write` set: reject with cause 11.
  - A rejected operation is dropped. The unit stays in IDLE, no `wb_valid` is produced, and `err` is set.
  - Neither `ex_read` nor `ex_write` set: the operation is ignored silently.
- REQ: `mem_req`=1, with `mem_we`, `mem_addr`, `mem_wdata` driven from the latched values and held stable.
  - `mem_ack` sampled high: capture `mem_rdata` (loads only) into `wb_data`, then go to RESP.
  - The wait counter increments each REQ cycle without ack. When it reaches TIMEOUT, abort: set `err` with cause 01, set `wb_err`, force `wb_data`=0, go to RESP.
- RESP: `wb_valid`=1 for exactly one cycle, then go to IDLE. `wb_is_load`, `wb_err` and `wb_data` are valid only while `wb_valid`=1.
- `mem_ack` outside REQ is ignored.
- `err` priority:
  - `err_cause` holds the first cause; later errors do not overwrite it while `err`=1.
  - `err_clr` and a new error in the same cycle: the new error wins.
- Reset (asynchronous, including mid-transaction):
  - FSM returns to IDLE immediately.
  - `mem_req`, `mem_we`, `wb_valid`, `wb_is_load`, `wb_err`, `err` = 0; `err_cause`=00; `mem_addr`, `mem_wdata`, `wb_data` = 0; counter = 0.
  - `ex_ready`=1 and `stall`=0.
  - An in-flight transaction is abandoned and produces no `wb_valid`.

## Timing
- Accept at edge N. `mem_req` is high in cycle N+1 and stays high through the cycle in which `mem_ack` is high (cycle N+k, k≥1).
- `wb_valid` is high in cycle N+k+1. `ex_ready` returns high in cycle N+k+2.
- Minimum occupancy is 3 cycles per operation (ack in the first REQ cycle). Throughput is at most one operation per 3 cycles.
- Timeout: with no ack, `mem_req` is high for exactly TIMEOUT cycles, then drops. `wb_valid` with `wb_err`=1 follows in the next cycle, and `err` rises in the same cycle as `wb_valid`.
- Rejection: `err` rises on the edge following the offending cycle. `ex_ready` stays 1.

## Test plan
- Load, addr 3, memory model with 0-wait ack returning 19: `mem_req` high for 1 cycle, then `wb_valid`=1, `wb_is_load`=1, `wb_data`=19; `ex_ready` is back 3 cycles after accept.
- Store, addr 5, data 0xDEAD, ack delayed 4 cycles: `mem_req`, `mem_we`=1 and `mem_addr`=5 held stable for 4 cycles; then `wb_valid`=1, `wb_is_load`=0, `wb_data`=0; a subsequent load from 5 returns 0xDEAD.
- Load with ack never asserted, TIMEOUT=15: `mem_req` high for exactly 15 cycles, then `wb_valid`=1, `wb_err`=1, `wb_data`=0, `err`=1, `err_cause`=01.
- Error reporting, in order:
  - `ex_read` & `ex_write` both set, addr 2: no `mem_req`, `err_cause`=10.
  - Load from addr 256: rejected, `err_cause` stays 10.
  - `err_clr`: `err`=0, `err_cause`=00.
- `resetn` pulsed low during the 2nd REQ cycle: `mem_req` drops asynchronously, no `wb_valid` is produced, `ex_ready`=1 after release, and the next load from addr 4 returns 6.
